// File: rtl/sram_rr_arb2.sv
// Two-requester round-robin arbiter in front of one single-port SRAM.
// Each requester has a valid/ready handshake and can lock the SRAM for a
// burst of up to BURST_MAX beats. Read data returns to the requester that
// issued the read, one cycle after the access.
module sram_rr_arb2 #(
  parameter int WIDTH     = 64,
  parameter int ADDR_W    = 11,
  parameter int BURST_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_wr,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [WIDTH-1:0]  req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_wr,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [WIDTH-1:0]  req1_wdata,
  output logic              rd0_valid,
  output logic [WIDTH-1:0]  rd0_data,
  output logic              rd1_valid,
  output logic [WIDTH-1:0]  rd1_data,
  output logic              sram_CEN,
  output logic              sram_WEN,
  output logic [ADDR_W-1:0] sram_A,
  output logic [WIDTH-1:0]  sram_D,
  input  logic [WIDTH-1:0]  sram_Q
);

  localparam int CNT_W    = $clog2(BURST_MAX + 1);
  // A one-beat burst limit makes locking meaningless, so lock is ignored then.
  localparam bit CAN_LOCK = (BURST_MAX > 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t             state_reg;
  logic               rr_ptr_reg;
  logic [CNT_W-1:0]   beat_cnt_reg;
  logic [1:0]         rd_pend_reg;

  logic [1:0]         valid;
  logic [1:0]         wr;
  logic [1:0]         grant;
  logic               accept;
  logic               sel;
  logic               sel_wr;
  logic               sel_lock;
  logic [ADDR_W-1:0]  sel_addr;
  logic [WIDTH-1:0]   sel_wdata;
  logic               lock_owner;
  logic               owner_valid;
  logic               owner_lock;
  logic [CNT_W-1:0]   beat_cnt_next;

  assign valid = {req1_valid, req0_valid};
  assign wr    = {req1_wr, req0_wr};

  // Grant depends only on valid, state and rr_ptr; reset masks everything.
  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      case (state_reg)
        IDLE: begin
          grant[0] = valid[0] & (~valid[1] | ~rr_ptr_reg);
          grant[1] = valid[1] & (~valid[0] |  rr_ptr_reg);
        end
        LOCK0:   grant[0] = valid[0];
        LOCK1:   grant[1] = valid[1];
        default: grant = 2'b00;
      endcase
    end
  end

  assign accept    = |grant;
  assign sel       = grant[1];
  assign sel_wr    = sel ? req1_wr    : req0_wr;
  assign sel_lock  = sel ? req1_lock  : req0_lock;
  assign sel_addr  = sel ? req1_addr  : req0_addr;
  assign sel_wdata = sel ? req1_wdata : req0_wdata;

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // The accepted beat goes straight to the SRAM pins in the same cycle.
  assign sram_CEN = ~accept;
  assign sram_WEN = accept ? ~sel_wr : 1'b1;
  assign sram_A   = accept ? sel_addr  : '0;
  assign sram_D   = accept ? sel_wdata : '0;

  // Pending reads surface one cycle later; a reset cycle swallows them.
  assign rd0_valid = rd_pend_reg[0] & ~reset;
  assign rd1_valid = rd_pend_reg[1] & ~reset;
  assign rd0_data  = sram_Q;
  assign rd1_data  = sram_Q;

  assign lock_owner    = (state_reg == LOCK1);
  assign owner_valid   = lock_owner ? req1_valid : req0_valid;
  assign owner_lock    = lock_owner ? req1_lock  : req0_lock;
  assign beat_cnt_next = beat_cnt_reg + CNT_W'(1);

  // Arbitration state: lock tracking, burst counting, fairness pointer, read pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= 1'b0;
      beat_cnt_reg <= '0;
      rd_pend_reg  <= 2'b00;
    end else begin
      rd_pend_reg <= grant & ~wr;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (sel == rr_ptr_reg) rr_ptr_reg <= ~sel;
            if (sel_lock && CAN_LOCK) begin
              state_reg    <= sel ? LOCK1 : LOCK0;
              beat_cnt_reg <= CNT_W'(1);
            end
          end
        end
        LOCK0, LOCK1: begin
          // Owner idle for a cycle, lock released, or burst cap reached: end the lock
          // and favour the other requester next.
          if (!owner_valid || !owner_lock || beat_cnt_next == CNT_W'(BURST_MAX)) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            rr_ptr_reg   <= ~lock_owner;
          end else begin
            beat_cnt_reg <= beat_cnt_next;
          end
        end
        default: begin
          state_reg    <= IDLE;
          beat_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rr_arb2.sv
// Bench for sram_rr_arb2: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbitration rules and SRAM contents.
module tb_sram_rr_arb2;

  localparam int WIDTH     = 64;
  localparam int ADDR_W    = 11;
  localparam int BURST_MAX = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req0_ready, req0_wr, req0_lock;
  logic [ADDR_W-1:0] req0_addr;
  logic [WIDTH-1:0]  req0_wdata;
  logic              req1_valid, req1_ready, req1_wr, req1_lock;
  logic [ADDR_W-1:0] req1_addr;
  logic [WIDTH-1:0]  req1_wdata;
  logic              rd0_valid, rd1_valid;
  logic [WIDTH-1:0]  rd0_data, rd1_data;
  logic              sram_CEN, sram_WEN;
  logic [ADDR_W-1:0] sram_A;
  logic [WIDTH-1:0]  sram_D;
  logic [WIDTH-1:0]  sram_Q;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_rr_arb2 #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
    .req0_lock(req0_lock), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
    .req1_lock(req1_lock), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rd0_valid(rd0_valid), .rd0_data(rd0_data),
    .rd1_valid(rd1_valid), .rd1_data(rd1_data),
    .sram_CEN(sram_CEN), .sram_WEN(sram_WEN), .sram_A(sram_A),
    .sram_D(sram_D), .sram_Q(sram_Q)
  );

  // Behavioural single-port SRAM: write or read at the edge, Q holds last read.
  logic [WIDTH-1:0] mem [2048];
  logic [WIDTH-1:0] q_reg = '0;
  always @(posedge clk) begin
    if (!sram_CEN) begin
      if (!sram_WEN) mem[sram_A] <= sram_D;
      else           q_reg <= mem[sram_A];
    end
  end
  assign sram_Q = q_reg;

  // Expected memory contents, updated only from the bench's own knowledge of writes.
  logic [WIDTH-1:0] exp_mem [2048];

  function automatic logic [WIDTH-1:0] pat(input int i);
    logic [31:0] v;
    v = i;
    return {32'hC0DE_0000 + v, ~v};
  endfunction

  task automatic clear_inputs();
    req0_valid = 0; req0_wr = 0; req0_lock = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_wr = 0; req1_lock = 0; req1_addr = '0; req1_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    clear_inputs();
    repeat (n) next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1; req0_wr = 1; req0_addr = 11'h123; req0_wdata = 64'h1111;
    req1_valid = 1; req1_wr = 0; req1_addr = 11'h321;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL reset_ready0 got=%0b exp=0", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready1 got=%0b exp=0", req1_ready); end
      checks++; if (sram_CEN !== 1'b1) begin failures++; $display("FAIL reset_cen got=%0b exp=1", sram_CEN); end
      checks++; if (sram_WEN !== 1'b1 || sram_A !== '0 || sram_D !== '0) begin failures++; $display("FAIL reset_pins got=%0b/%0h/%0h exp=1/0/0", sram_WEN, sram_A, sram_D); end
      checks++; if (rd0_valid !== 1'b0 || rd1_valid !== 1'b0) begin failures++; $display("FAIL reset_rdv got=%0b%0b exp=00", rd1_valid, rd0_valid); end
      next_cycle();
    end
    reset = 1'b0;
    clear_inputs();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (rd0_valid !== 1'b0 || rd1_valid !== 1'b0) begin failures++; $display("FAIL post_reset_rdv got=%0b%0b exp=00", rd1_valid, rd0_valid); end
      next_cycle();
    end
  endtask

  task automatic test_write_read();
    apply_reset(1);
    req0_valid = 1; req0_wr = 1; req0_addr = 11'h0A5; req0_wdata = 64'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL wr_ready got=%0b exp=1", req0_ready); end
    checks++; if (sram_CEN !== 1'b0 || sram_WEN !== 1'b0 || sram_A !== 11'h0A5 || sram_D !== 64'hDEAD_BEEF)
      begin failures++; $display("FAIL wr_pins got=%0b/%0b/%0h/%0h exp=0/0/a5/deadbeef", sram_CEN, sram_WEN, sram_A, sram_D); end
    exp_mem[11'h0A5] = 64'hDEAD_BEEF;
    next_cycle();
    req0_wr = 0;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || sram_WEN !== 1'b1 || sram_CEN !== 1'b0) begin failures++; $display("FAIL rd_issue got=%0b/%0b/%0b exp=1/1/0", req0_ready, sram_WEN, sram_CEN); end
    checks++; if (rd0_valid !== 1'b0) begin failures++; $display("FAIL wr_no_rdv got=%0b exp=0", rd0_valid); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (rd0_valid !== 1'b1) begin failures++; $display("FAIL rd0_valid got=%0b exp=1", rd0_valid); end
    checks++; if (rd0_data !== 64'hDEAD_BEEF) begin failures++; $display("FAIL rd0_data got=%0h exp=deadbeef", rd0_data); end
    checks++; if (rd1_valid !== 1'b0) begin failures++; $display("FAIL rd1_quiet got=%0b exp=0", rd1_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if (rd0_valid !== 1'b0) begin failures++; $display("FAIL rd0_one_shot got=%0b exp=0", rd0_valid); end
    next_cycle();
  endtask

  task automatic test_alternate();
    int prev;
    apply_reset(1);
    prev = -1;
    req0_valid = 1; req0_addr = 11'd0;
    req1_valid = 1; req1_addr = 11'd1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (req0_ready !== (c % 2 == 0) || req1_ready !== (c % 2 == 1))
        begin failures++; $display("FAIL alt_grant c=%0d got=%0b%0b exp=%0b%0b", c, req1_ready, req0_ready, c % 2 == 1, c % 2 == 0); end
      checks++; if (sram_CEN !== 1'b0 || sram_A !== ADDR_W'(c % 2))
        begin failures++; $display("FAIL alt_access c=%0d got=%0b/%0h exp=0/%0h", c, sram_CEN, sram_A, c % 2); end
      checks++; if (rd0_valid !== (prev == 0) || rd1_valid !== (prev == 1))
        begin failures++; $display("FAIL alt_rdv c=%0d got=%0b%0b prev=%0d", c, rd1_valid, rd0_valid, prev); end
      if (prev >= 0) begin
        checks++; if ((prev == 0 ? rd0_data : rd1_data) !== pat(prev))
          begin failures++; $display("FAIL alt_rdata c=%0d got=%0h exp=%0h", c, sram_Q, pat(prev)); end
      end
      prev = c % 2;
      next_cycle();
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_burst_limit();
    apply_reset(1);
    req0_valid = 1; req0_lock = 1;
    req1_valid = 1; req1_addr = 11'h7FF;
    for (int c = 0; c < 21; c++) begin
      req0_addr = ADDR_W'(c);
      if (c > 16) req1_valid = 0;
      @(negedge clk);
      checks++; if (req0_ready !== (c != 16) || req1_ready !== (c == 16))
        begin failures++; $display("FAIL burst_grant c=%0d got=%0b%0b exp=%0b%0b", c, req1_ready, req0_ready, c == 16, c != 16); end
      next_cycle();
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_lock_drop();
    apply_reset(1);
    req0_valid = 1; req0_lock = 1; req1_valid = 1;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL drop_c0 got=%0b%0b exp=01", req1_ready, req0_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL drop_locked got=%0b%0b exp=01", req1_ready, req0_ready); end
    next_cycle();
    req0_valid = 0;
    @(negedge clk);
    checks++; if (req1_ready !== 1'b0 || sram_CEN !== 1'b1) begin failures++; $display("FAIL drop_gap got=%0b/%0b exp=0/1", req1_ready, sram_CEN); end
    next_cycle();
    req0_valid = 1;
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin failures++; $display("FAIL drop_handover got=%0b%0b exp=10", req1_ready, req0_ready); end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset(1);
    req1_valid = 1; req1_lock = 1;
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL mid_enter got=%0b exp=1", req1_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1 || sram_WEN !== 1'b1) begin failures++; $display("FAIL mid_read got=%0b/%0b exp=1/1", req1_ready, sram_WEN); end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (rd1_valid !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL mid_reset got=%0b/%0b exp=0/0", rd1_valid, req1_ready); end
    next_cycle();
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++; if (rd1_valid !== 1'b0) begin failures++; $display("FAIL mid_after got=%0b exp=0", rd1_valid); end
    next_cycle();
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL mid_idle_rr got=%0b%0b exp=01", req1_ready, req0_ready); end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_random();
    int               owner, beats, fav, eg;
    bit               pend [2];
    logic [WIDTH-1:0] pdata [2];
    bit               vv [2], wrr [2], lk [2], rst;
    logic [ADDR_W-1:0] aa [2];
    logic [WIDTH-1:0] wd [2];
    apply_reset(1);
    owner = -1; beats = 0; fav = 0;
    pend[0] = 0; pend[1] = 0; pdata[0] = '0; pdata[1] = '0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int n = 0; n < 2; n++) begin
        vv[n]  = ($urandom_range(0, 3) != 0);
        wrr[n] = $urandom_range(0, 1);
        lk[n]  = ($urandom_range(0, 9) < 7);
        aa[n]  = ADDR_W'($urandom_range(0, 15));
        wd[n]  = {$urandom, $urandom};
      end
      reset = rst;
      req0_valid = vv[0]; req0_wr = wrr[0]; req0_lock = lk[0]; req0_addr = aa[0]; req0_wdata = wd[0];
      req1_valid = vv[1]; req1_wr = wrr[1]; req1_lock = lk[1]; req1_addr = aa[1]; req1_wdata = wd[1];
      @(negedge clk);
      eg = -1;
      if (!rst) begin
        if (owner >= 0) begin
          if (vv[owner]) eg = owner;
        end else if (vv[0] && vv[1]) eg = fav;
        else if (vv[0]) eg = 0;
        else if (vv[1]) eg = 1;
      end
      checks++; if (req0_ready !== (eg == 0) || req1_ready !== (eg == 1))
        begin failures++; $display("FAIL rnd_grant c=%0d got=%0b%0b exp_grant=%0d", c, req1_ready, req0_ready, eg); end
      checks++; if (sram_CEN !== (eg < 0)) begin failures++; $display("FAIL rnd_cen c=%0d got=%0b exp=%0b", c, sram_CEN, eg < 0); end
      if (eg >= 0) begin
        $display("txn c=%0d req=%0d %s addr=%0h lock=%0b", c, eg, wrr[eg] ? "wr" : "rd", aa[eg], lk[eg]);
        checks++; if (sram_WEN !== !wrr[eg] || sram_A !== aa[eg] || (wrr[eg] && sram_D !== wd[eg]))
          begin failures++; $display("FAIL rnd_pins c=%0d got=%0b/%0h/%0h exp=%0b/%0h/%0h", c, sram_WEN, sram_A, sram_D, !wrr[eg], aa[eg], wd[eg]); end
      end else begin
        checks++; if (sram_WEN !== 1'b1 || sram_A !== '0 || sram_D !== '0)
          begin failures++; $display("FAIL rnd_idle_pins c=%0d got=%0b/%0h/%0h exp=1/0/0", c, sram_WEN, sram_A, sram_D); end
      end
      checks++; if (rd0_valid !== (pend[0] && !rst) || rd1_valid !== (pend[1] && !rst))
        begin failures++; $display("FAIL rnd_rdv c=%0d got=%0b%0b exp=%0b%0b", c, rd1_valid, rd0_valid, pend[1] && !rst, pend[0] && !rst); end
      if (pend[0] && !rst) begin
        checks++; if (rd0_data !== pdata[0]) begin failures++; $display("FAIL rnd_rd0 c=%0d got=%0h exp=%0h", c, rd0_data, pdata[0]); end
      end
      if (pend[1] && !rst) begin
        checks++; if (rd1_data !== pdata[1]) begin failures++; $display("FAIL rnd_rd1 c=%0d got=%0h exp=%0h", c, rd1_data, pdata[1]); end
      end
      for (int n = 0; n < 2; n++) begin
        pend[n]  = (eg == n) && !wrr[n];
        pdata[n] = exp_mem[aa[n]];
      end
      if (eg >= 0 && wrr[eg]) exp_mem[aa[eg]] = wd[eg];
      if (rst) begin
        owner = -1; beats = 0; fav = 0;
      end else if (owner >= 0) begin
        if (eg < 0) begin
          fav = 1 - owner; owner = -1; beats = 0;
        end else begin
          beats++;
          if (!lk[owner] || beats == BURST_MAX) begin
            fav = 1 - owner; owner = -1; beats = 0;
          end
        end
      end else if (eg >= 0) begin
        if (eg == fav) fav = 1 - eg;
        if (lk[eg] && BURST_MAX > 1) begin
          owner = eg; beats = 1;
        end
      end
      next_cycle();
    end
    reset = 1'b0;
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    for (int i = 0; i < 2048; i++) begin
      mem[i]     = pat(i);
      exp_mem[i] = pat(i);
    end
    #1;
    test_reset();
    test_write_read();
    test_alternate();
    test_burst_limit();
    test_lock_drop();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
